// File: rtl/axi_rom_rd_ctrl.sv
// AXI4-Lite read-only front end for a synchronous ROM.
// Reads are translated to ROM word indices and answered after the ROM's
// registered data returns. Writes are accepted and always answered with SLVERR.
module axi_rom_rd_ctrl #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned AXI_ADDR_WIDTH = 16,
    parameter int unsigned ROM_ADDR_WIDTH = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    // AR channel
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr_i,
    input  logic                      s_axi_arvalid_i,
    output logic                      s_axi_arready_o,
    // R channel
    output logic [DATA_WIDTH-1:0]     s_axi_rdata_o,
    output logic [1:0]                s_axi_rresp_o,
    output logic                      s_axi_rvalid_o,
    input  logic                      s_axi_rready_i,
    // AW channel
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr_i,
    input  logic                      s_axi_awvalid_i,
    output logic                      s_axi_awready_o,
    // W channel
    input  logic [DATA_WIDTH-1:0]     s_axi_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb_i,
    input  logic                      s_axi_wvalid_i,
    output logic                      s_axi_wready_o,
    // B channel
    output logic [1:0]                s_axi_bresp_o,
    output logic                      s_axi_bvalid_o,
    input  logic                      s_axi_bready_i,
    // ROM port
    output logic [ROM_ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [DATA_WIDTH-1:0]     rom_data_i
);

    localparam int unsigned LSB = $clog2(DATA_WIDTH / 8);
    localparam int unsigned HI  = LSB + ROM_ADDR_WIDTH;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {RdIdle, RdRomWait, RdCapture, RdResp} rd_state_e;
    typedef enum logic [1:0] {WrIdle, WrGotAw, WrGotW, WrResp} wr_state_e;

    rd_state_e rd_state_q, rd_state_d;
    wr_state_e wr_state_q, wr_state_d;

    logic [ROM_ADDR_WIDTH-1:0] rom_addr_q;
    logic                      oor_q;
    logic [DATA_WIDTH-1:0]     rdata_q;
    logic [1:0]                rresp_q;

    logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic ar_oor;

    // Write address/data contents are irrelevant: every write is rejected.
    logic unused_wr;
    assign unused_wr = ^{s_axi_awaddr_i, s_axi_wdata_i, s_axi_wstrb_i};

    assign ar_hs = s_axi_arvalid_i & s_axi_arready_o;
    assign r_hs  = s_axi_rvalid_o & s_axi_rready_i;
    assign aw_hs = s_axi_awvalid_i & s_axi_awready_o;
    assign w_hs  = s_axi_wvalid_i & s_axi_wready_o;
    assign b_hs  = s_axi_bvalid_o & s_axi_bready_i;

    // Any address bit above the ROM's word range makes the access out of range.
    assign ar_oor = (s_axi_araddr_i >> HI) != '0;

    assign rom_addr_o    = rom_addr_q;
    assign s_axi_rdata_o = rdata_q;
    assign s_axi_rresp_o = rresp_q;

    // Read FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_state_q <= RdIdle;
        end else begin
            rd_state_q <= rd_state_d;
        end
    end

    // Read FSM next state
    always_comb begin
        rd_state_d = rd_state_q;
        unique case (rd_state_q)
            RdIdle:    if (ar_hs) rd_state_d = RdRomWait;
            RdRomWait: rd_state_d = RdCapture;
            RdCapture: rd_state_d = RdResp;
            RdResp:    if (r_hs) rd_state_d = RdIdle;
            default:   rd_state_d = RdIdle;
        endcase
    end

    // Read FSM outputs; readies are held low while reset is asserted
    always_comb begin
        s_axi_arready_o = 1'b0;
        s_axi_rvalid_o  = 1'b0;
        unique case (rd_state_q)
            RdIdle:  s_axi_arready_o = ~rst_i;
            RdResp:  s_axi_rvalid_o  = 1'b1;
            default: ;
        endcase
    end

    // Read datapath: ROM index on AR accept, response capture one cycle after ROM data
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rom_addr_q <= '0;
            oor_q      <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            if (ar_hs) begin
                rom_addr_q <= s_axi_araddr_i[LSB +: ROM_ADDR_WIDTH];
                oor_q      <= ar_oor;
            end
            if (rd_state_q == RdCapture) begin
                rdata_q <= oor_q ? '0 : rom_data_i;
                rresp_q <= oor_q ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    // Write FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_state_q <= WrIdle;
        end else begin
            wr_state_q <= wr_state_d;
        end
    end

    // Write FSM next state: collect AW and W in either order, then respond
    always_comb begin
        wr_state_d = wr_state_q;
        unique case (wr_state_q)
            WrIdle: begin
                if (aw_hs && w_hs) wr_state_d = WrResp;
                else if (aw_hs)    wr_state_d = WrGotAw;
                else if (w_hs)     wr_state_d = WrGotW;
            end
            WrGotAw: if (w_hs) wr_state_d = WrResp;
            WrGotW:  if (aw_hs) wr_state_d = WrResp;
            WrResp:  if (b_hs) wr_state_d = WrIdle;
            default: wr_state_d = WrIdle;
        endcase
    end

    // Write FSM outputs
    always_comb begin
        s_axi_awready_o = 1'b0;
        s_axi_wready_o  = 1'b0;
        s_axi_bvalid_o  = 1'b0;
        s_axi_bresp_o   = RESP_OKAY;
        unique case (wr_state_q)
            WrIdle: begin
                s_axi_awready_o = ~rst_i;
                s_axi_wready_o  = ~rst_i;
            end
            WrGotAw: s_axi_wready_o  = ~rst_i;
            WrGotW:  s_axi_awready_o = ~rst_i;
            WrResp: begin
                s_axi_bvalid_o = 1'b1;
                s_axi_bresp_o  = RESP_SLVERR;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_rom_rd_ctrl.sv
// Directed bench for axi_rom_rd_ctrl with a synchronous ROM model and
// expected-response queues for the R and B channels.
module tb_axi_rom_rd_ctrl;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int RW = 8;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [AW-1:0] s_axi_araddr_i = '0;
    logic          s_axi_arvalid_i = 1'b0;
    logic          s_axi_arready_o;
    logic [DW-1:0] s_axi_rdata_o;
    logic [1:0]    s_axi_rresp_o;
    logic          s_axi_rvalid_o;
    logic          s_axi_rready_i = 1'b0;
    logic [AW-1:0] s_axi_awaddr_i = '0;
    logic          s_axi_awvalid_i = 1'b0;
    logic          s_axi_awready_o;
    logic [DW-1:0] s_axi_wdata_i = '0;
    logic [DW/8-1:0] s_axi_wstrb_i = '0;
    logic          s_axi_wvalid_i = 1'b0;
    logic          s_axi_wready_o;
    logic [1:0]    s_axi_bresp_o;
    logic          s_axi_bvalid_o;
    logic          s_axi_bready_i = 1'b0;
    logic [RW-1:0] rom_addr_o;
    logic [DW-1:0] rom_data_i = '0;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rd_exp_t;

    rd_exp_t    rd_q[$];
    logic [1:0] wr_q[$];
    int         errors = 0;
    int         checks = 0;

    axi_rom_rd_ctrl #(
        .DATA_WIDTH    (DW),
        .AXI_ADDR_WIDTH(AW),
        .ROM_ADDR_WIDTH(RW)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .s_axi_araddr_i (s_axi_araddr_i),
        .s_axi_arvalid_i(s_axi_arvalid_i),
        .s_axi_arready_o(s_axi_arready_o),
        .s_axi_rdata_o  (s_axi_rdata_o),
        .s_axi_rresp_o  (s_axi_rresp_o),
        .s_axi_rvalid_o (s_axi_rvalid_o),
        .s_axi_rready_i (s_axi_rready_i),
        .s_axi_awaddr_i (s_axi_awaddr_i),
        .s_axi_awvalid_i(s_axi_awvalid_i),
        .s_axi_awready_o(s_axi_awready_o),
        .s_axi_wdata_i  (s_axi_wdata_i),
        .s_axi_wstrb_i  (s_axi_wstrb_i),
        .s_axi_wvalid_i (s_axi_wvalid_i),
        .s_axi_wready_o (s_axi_wready_o),
        .s_axi_bresp_o  (s_axi_bresp_o),
        .s_axi_bvalid_o (s_axi_bvalid_o),
        .s_axi_bready_i (s_axi_bready_i),
        .rom_addr_o     (rom_addr_o),
        .rom_data_i     (rom_data_i)
    );

    always #5 clk_i = ~clk_i;

    // ROM contents: word 1 is a known marker, the rest a per-index pattern
    function automatic logic [31:0] rom_word(input logic [7:0] i);
        if (i == 8'd1) return 32'hDEADBEEF;
        return {i, ~i, i ^ 8'h5A, i + 8'd3};
    endfunction

    // Synchronous ROM: data one cycle after address
    always @(posedge clk_i) rom_data_i <= rom_word(rom_addr_o);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One read; outputs sampled at negedge, inputs changed at negedge
    task automatic rd(input logic [15:0] addr, input int stall, input string tag);
        rd_exp_t e;
        rd_exp_t got;
        int      n;
        logic    oor;
        n = 0;
        while (s_axi_arready_o !== 1'b1 && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check({tag, "_arready_t0"}, 64'(s_axi_arready_o), 64'd1);
        oor    = addr[15:10] != 6'd0;
        e.data = oor ? 32'h0 : rom_word(addr[9:2]);
        e.resp = oor ? 2'b10 : 2'b00;
        rd_q.push_back(e);
        s_axi_araddr_i  = addr;
        s_axi_arvalid_i = 1'b1;
        @(negedge clk_i);
        s_axi_arvalid_i = 1'b0;
        check({tag, "_romaddr_t1"}, 64'(rom_addr_o), 64'(addr[9:2]));
        check({tag, "_arready_t1"}, 64'(s_axi_arready_o), 64'd0);
        @(negedge clk_i);
        check({tag, "_arready_t2"}, 64'(s_axi_arready_o), 64'd0);
        check({tag, "_rvalid_t2"}, 64'(s_axi_rvalid_o), 64'd0);
        @(negedge clk_i);
        check({tag, "_rvalid_t3"}, 64'(s_axi_rvalid_o), 64'd1);
        check({tag, "_arready_t3"}, 64'(s_axi_arready_o), 64'd0);
        for (int i = 0; i < stall; i++) begin
            check({tag, "_stall_rvalid"}, 64'(s_axi_rvalid_o), 64'd1);
            check({tag, "_stall_rdata"}, 64'(s_axi_rdata_o), 64'(e.data));
            @(negedge clk_i);
        end
        s_axi_rready_i = 1'b1;
        got = rd_q.pop_front();
        check({tag, "_rvalid_hs"}, 64'(s_axi_rvalid_o), 64'd1);
        check({tag, "_rdata"}, 64'(s_axi_rdata_o), 64'(got.data));
        check({tag, "_rresp"}, 64'(s_axi_rresp_o), 64'(got.resp));
        @(negedge clk_i);
        s_axi_rready_i = 1'b0;
        check({tag, "_rvalid_after"}, 64'(s_axi_rvalid_o), 64'd0);
        check({tag, "_arready_after"}, 64'(s_axi_arready_o), 64'd1);
    endtask

    // AW and W presented together
    task automatic wr_simple(input string tag);
        check({tag, "_awready_t0"}, 64'(s_axi_awready_o), 64'd1);
        check({tag, "_wready_t0"}, 64'(s_axi_wready_o), 64'd1);
        wr_q.push_back(2'b10);
        s_axi_awaddr_i  = 16'h0010;
        s_axi_wdata_i   = 32'h12345678;
        s_axi_wstrb_i   = 4'hF;
        s_axi_awvalid_i = 1'b1;
        s_axi_wvalid_i  = 1'b1;
        @(negedge clk_i);
        s_axi_awvalid_i = 1'b0;
        s_axi_wvalid_i  = 1'b0;
        check({tag, "_bvalid_t1"}, 64'(s_axi_bvalid_o), 64'd1);
        check({tag, "_awready_t1"}, 64'(s_axi_awready_o), 64'd0);
        check({tag, "_wready_t1"}, 64'(s_axi_wready_o), 64'd0);
        s_axi_bready_i = 1'b1;
        check({tag, "_bresp"}, 64'(s_axi_bresp_o), 64'(wr_q.pop_front()));
        @(negedge clk_i);
        s_axi_bready_i = 1'b0;
        check({tag, "_bvalid_after"}, 64'(s_axi_bvalid_o), 64'd0);
        check({tag, "_awready_after"}, 64'(s_axi_awready_o), 64'd1);
        check({tag, "_wready_after"}, 64'(s_axi_wready_o), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset values
        repeat (2) @(negedge clk_i);
        check("rst_arready", 64'(s_axi_arready_o), 64'd0);
        check("rst_awready", 64'(s_axi_awready_o), 64'd0);
        check("rst_wready", 64'(s_axi_wready_o), 64'd0);
        check("rst_rvalid", 64'(s_axi_rvalid_o), 64'd0);
        check("rst_bvalid", 64'(s_axi_bvalid_o), 64'd0);
        check("rst_rdata", 64'(s_axi_rdata_o), 64'd0);
        check("rst_rresp", 64'(s_axi_rresp_o), 64'd0);
        check("rst_bresp", 64'(s_axi_bresp_o), 64'd0);
        check("rst_romaddr", 64'(rom_addr_o), 64'd0);
        rst_i = 1'b0;
        #1;
        check("rel_arready", 64'(s_axi_arready_o), 64'd1);
        check("rel_awready", 64'(s_axi_awready_o), 64'd1);
        check("rel_wready", 64'(s_axi_wready_o), 64'd1);
        @(negedge clk_i);

        // Basic reads, back-pressure and range boundaries
        rd(16'h0004, 0, "rd_w1");
        rd(16'h0004, 5, "rd_w1_stall");
        rd(16'h0400, 0, "rd_oor");
        rd(16'h03FC, 0, "rd_w255");
        rd(16'h0006, 0, "rd_unaligned");
        rd(16'hFFFC, 1, "rd_oor_top");

        // W two cycles before AW, then a second write offered before bready
        check("wf_wready_t0", 64'(s_axi_wready_o), 64'd1);
        s_axi_wvalid_i = 1'b1;
        @(negedge clk_i);
        s_axi_wvalid_i = 1'b0;
        check("wf_wready_low", 64'(s_axi_wready_o), 64'd0);
        check("wf_awready_high", 64'(s_axi_awready_o), 64'd1);
        check("wf_bvalid_early1", 64'(s_axi_bvalid_o), 64'd0);
        @(negedge clk_i);
        check("wf_bvalid_early2", 64'(s_axi_bvalid_o), 64'd0);
        s_axi_awvalid_i = 1'b1;
        wr_q.push_back(2'b10);
        @(negedge clk_i);
        s_axi_awvalid_i = 1'b0;
        check("wf_bvalid_t1", 64'(s_axi_bvalid_o), 64'd1);
        check("wf_awready_t1", 64'(s_axi_awready_o), 64'd0);
        s_axi_awvalid_i = 1'b1;
        s_axi_wvalid_i  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("wf_hold_bvalid", 64'(s_axi_bvalid_o), 64'd1);
            check("wf_block_awready", 64'(s_axi_awready_o), 64'd0);
            check("wf_block_wready", 64'(s_axi_wready_o), 64'd0);
        end
        s_axi_awvalid_i = 1'b0;
        s_axi_wvalid_i  = 1'b0;
        s_axi_bready_i  = 1'b1;
        check("wf_bresp", 64'(s_axi_bresp_o), 64'(wr_q.pop_front()));
        @(negedge clk_i);
        s_axi_bready_i = 1'b0;
        check("wf_bvalid_done", 64'(s_axi_bvalid_o), 64'd0);
        check("wf_awready_back", 64'(s_axi_awready_o), 64'd1);
        check("wf_wready_back", 64'(s_axi_wready_o), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("wf_single_b", 64'(s_axi_bvalid_o), 64'd0);
        end

        // Reset during the ROM wait cycle aborts the read
        s_axi_araddr_i  = 16'h0004;
        s_axi_arvalid_i = 1'b1;
        @(negedge clk_i);
        s_axi_arvalid_i = 1'b0;
        rst_i = 1'b1;
        check("abort_arready_in_rst", 64'(s_axi_arready_o), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("abort_arready_back", 64'(s_axi_arready_o), 64'd1);
        check("abort_romaddr", 64'(rom_addr_o), 64'd0);
        for (int i = 0; i < 5; i++) begin
            check("abort_no_rvalid", 64'(s_axi_rvalid_o), 64'd0);
            @(negedge clk_i);
        end
        rd(16'h0004, 0, "rd_after_abort");

        // Concurrent read and write
        fork
            rd(16'h0008, 2, "cc_rd");
            wr_simple("cc_wr");
        join
        wr_simple("wr_again");

        check("rd_queue_empty", 64'(rd_q.size()), 64'd0);
        check("wr_queue_empty", 64'(wr_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
